// File: rtl/float_recip_arbiter.sv
// Round-robin front end that shares one fully pipelined float reciprocal unit among several
// requesters, tagging each operand with its requester id and realigning it with the result.
module float_recip_arbiter #(
    parameter int  REQUESTERS    = 4,
    parameter int  MANTISSA_SIZE = 23,
    parameter int  EXPONENT_SIZE = 8,
    parameter int  LATENCY       = 11,
    localparam int FLOAT_SIZE    = 1 + EXPONENT_SIZE + MANTISSA_SIZE,
    localparam int ID_SIZE       = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             enable,
    input  logic [REQUESTERS-1:0]            s_valid,
    output logic [REQUESTERS-1:0]            s_ready,
    input  logic [REQUESTERS*FLOAT_SIZE-1:0] s_data,
    output logic [FLOAT_SIZE-1:0]            recip_in,
    input  logic [FLOAT_SIZE-1:0]            recip_out,
    output logic                             m_valid,
    output logic [ID_SIZE-1:0]               m_id,
    output logic [FLOAT_SIZE-1:0]            m_data,
    output logic                             busy
);

    localparam logic [ID_SIZE:0]   REQ_COUNT = (ID_SIZE + 1)'(REQUESTERS);
    localparam logic [ID_SIZE-1:0] LAST_ID   = ID_SIZE'(REQUESTERS - 1);

    logic [FLOAT_SIZE-1:0] operand [REQUESTERS];

    logic [ID_SIZE-1:0]    ptr_q, ptr_d;
    logic [ID_SIZE:0]      cand;
    logic                  grant_found;
    logic [ID_SIZE-1:0]    grant_idx;
    logic                  xfer;

    logic [FLOAT_SIZE-1:0] recip_in_q, recip_in_d;
    logic [LATENCY:0]      tag_valid_q;
    logic [ID_SIZE-1:0]    tag_id_q [LATENCY+1];

    logic                  m_valid_q;
    logic [ID_SIZE-1:0]    m_id_q;
    logic [FLOAT_SIZE-1:0] m_data_q, m_data_d;

    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            operand[i] = s_data[i*FLOAT_SIZE +: FLOAT_SIZE];
        end
    end

    // Scan requesters starting at ptr, wrapping modulo REQUESTERS; the first valid one wins.
    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            cand = {1'b0, ptr_q} + (ID_SIZE + 1)'(k);
            if (cand >= REQ_COUNT) begin
                cand = cand - REQ_COUNT;
            end
            if (!grant_found && s_valid[cand[ID_SIZE-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_SIZE-1:0];
            end
        end
    end

    // Grants are suppressed during reset so nothing is consumed that will never be tracked.
    assign xfer = resetn & enable & grant_found;

    always_comb begin
        s_ready = '0;
        if (xfer) begin
            s_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        recip_in_d = '0;
        if (xfer) begin
            ptr_d      = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
            recip_in_d = operand[grant_idx];
        end
    end

    // The reciprocal pipeline cannot stall, so m_data only captures when the tag says it is ours.
    assign m_data_d = tag_valid_q[LATENCY] ? recip_out : m_data_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the id stages are reset alongside the valid bits so m_id is never X after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q       <= '0;
            recip_in_q  <= '0;
            tag_valid_q <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
            m_valid_q   <= 1'b0;
            m_id_q      <= '0;
            m_data_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            recip_in_q  <= recip_in_d;
            tag_valid_q <= (tag_valid_q << 1) | (LATENCY + 1)'(xfer);
            tag_id_q[0] <= grant_idx;
            for (int i = 1; i <= LATENCY; i++) begin
                tag_id_q[i] <= tag_id_q[i-1];
            end
            m_valid_q   <= tag_valid_q[LATENCY];
            m_id_q      <= tag_id_q[LATENCY];
            m_data_q    <= m_data_d;
        end
    end

    assign recip_in = recip_in_q;
    assign m_valid  = m_valid_q;
    assign m_id     = m_id_q;
    assign m_data   = m_data_q;
    assign busy     = (|tag_valid_q) | m_valid_q;

endmodule

// File: tb/tb_float_recip_arbiter.sv
// Bench for float_recip_arbiter: a delay-line stub stands in for the reciprocal unit, a
// round-robin reference model predicts grants and a scoreboard checks every result slot.
module tb_float_recip_arbiter;

    localparam int R   = 4;
    localparam int MS  = 23;
    localparam int ES  = 8;
    localparam int LAT = 11;
    localparam int FS  = 1 + ES + MS;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            resetn;
    logic            enable;
    logic [R-1:0]    s_valid;
    logic [R-1:0]    s_ready;
    logic [R*FS-1:0] s_data;
    logic [FS-1:0]   recip_in;
    logic [FS-1:0]   recip_out;
    logic            m_valid;
    logic [IDW-1:0]  m_id;
    logic [FS-1:0]   m_data;
    logic            busy;

    always #5 clk = ~clk;

    float_recip_arbiter #(
        .REQUESTERS   (R),
        .MANTISSA_SIZE(MS),
        .EXPONENT_SIZE(ES),
        .LATENCY      (LAT)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (enable),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .recip_in (recip_in),
        .recip_out(recip_out),
        .m_valid  (m_valid),
        .m_id     (m_id),
        .m_data   (m_data),
        .busy     (busy)
    );

    // Reciprocal stand-in: pure LAT-cycle delay with no reset, like the real datapath.
    logic [FS-1:0] stub_q [LAT];
    always @(posedge clk) begin
        stub_q[0] <= recip_in;
        for (int i = 1; i < LAT; i++) stub_q[i] <= stub_q[i-1];
    end
    assign recip_out = stub_q[LAT-1];

    typedef struct {
        int            due;
        int            id;
        logic [FS-1:0] data;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           pulses = 0;
    int           xfers = 0;
    int           mptr = 0;
    int           last_xfer = 0;
    bit           have_xfer = 1'b0;
    logic [R-1:0] reload = '0;
    logic [R-1:0] last_ready;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [FS-1:0] rand_float();
        return FS'($urandom());
    endfunction

    // Reference arbitration: first valid requester at or after the pointer, wrapping around.
    function automatic int model_grant();
        if (!resetn || !enable) return -1;
        for (int k = 0; k < R; k++) begin
            if (s_valid[(mptr + k) % R]) return (mptr + k) % R;
        end
        return -1;
    endfunction

    // One clock: entered at a negedge with inputs applied, returns at the next negedge.
    task automatic step();
        int           g;
        logic [R-1:0] exp_rdy;
        bit           exp_busy;
        exp_t         e;
        #2;
        g       = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("s_ready", 64'(s_ready), 64'(exp_rdy));
        exp_busy = resetn && have_xfer && (cyc - last_xfer >= 1) && (cyc - last_xfer <= LAT + 2);
        check("busy", 64'(busy), 64'(exp_busy));
        last_ready = s_ready;
        if (g >= 0) begin
            e.due  = cyc + LAT + 2;
            e.id   = g;
            e.data = s_data[g*FS +: FS];
            sb.push_back(e);
            mptr      = (g + 1) % R;
            last_xfer = cyc;
            have_xfer = 1'b1;
            xfers++;
        end
        if (!resetn) begin
            mptr      = 0;
            have_xfer = 1'b0;
            sb.delete();
        end
        @(negedge clk);
        if (g >= 0) begin
            if (reload[g]) s_data[g*FS +: FS] = rand_float();
            else           s_valid[g] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        s_valid = '0;
        reload  = '0;
        repeat (n) step();
    endtask

    task automatic load_all();
        for (int i = 0; i < R; i++) s_data[i*FS +: FS] = rand_float();
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        repeat (2) step();
        resetn = 1'b1;
    endtask

    // Monitor: every cycle the scoreboard decides whether a result is due right now.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0 && sb[0].due < cyc) begin
                check("m_valid_missed", 64'(sb[0].due), 64'(cyc));
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("m_valid", 64'(m_valid), 64'd1);
                check("m_id", 64'(m_id), 64'(e.id));
                check("m_data", 64'(m_data), 64'(e.data));
            end else begin
                check("m_valid_idle", 64'(m_valid), 64'd0);
            end
            if (m_valid) pulses++;
        end
    end

    initial begin
        int  p0;
        int  x0;
        int  waited;
        bit  double0;
        logic [R-1:0] prev_ready;

        resetn  = 1'b0;
        enable  = 1'b1;
        s_valid = '1;
        load_all();
        @(negedge clk);

        // Reset with every requester asking.
        repeat (3) step();
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_recip_in", 64'(recip_in), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        resetn = 1'b1;
        step();
        check("first_grant", 64'(last_ready), 64'(4'b0001));
        repeat (3) step();
        idle(LAT + 4);

        // Requester 2 alone sends 2.0.
        s_valid = 4'b0100;
        s_data[2*FS +: FS] = 32'h4000_0000;
        step();
        idle(LAT + 4);

        // All four continuously valid for 12 cycles from a fresh pointer.
        pulse_reset();
        load_all();
        s_valid = '1;
        reload  = '1;
        p0 = pulses;
        repeat (12) step();
        idle(LAT + 4);
        check("burst_pulses", 64'(pulses - p0), 64'd12);

        // Fairness: requester 0 always valid, requester 3 joins later.
        s_valid = 4'b0001;
        reload  = 4'b0001;
        s_data[0*FS +: FS] = rand_float();
        repeat (3) step();
        s_valid[3] = 1'b1;
        s_data[3*FS +: FS] = rand_float();
        waited     = 0;
        double0    = 1'b0;
        prev_ready = '0;
        while (waited < 8) begin
            step();
            if (last_ready[0] && prev_ready[0]) double0 = 1'b1;
            prev_ready = last_ready;
            if (last_ready[3]) break;
            waited++;
        end
        check("fair_wait_le3", 64'(waited <= 3), 64'd1);
        check("fair_no_double0", 64'(double0), 64'd0);
        idle(LAT + 4);

        // Three transfers, then enable drops while requests stay pending.
        load_all();
        s_valid = '1;
        reload  = '1;
        p0 = pulses;
        repeat (3) step();
        enable = 1'b0;
        repeat (LAT + 4) step();
        check("en_pulses", 64'(pulses - p0), 64'd3);
        check("en_busy_low", 64'(busy), 64'd0);
        enable = 1'b1;
        idle(2);

        // Five transfers, reset 4 cycles after the last one drops every tag.
        load_all();
        s_valid = '1;
        reload  = '1;
        x0 = xfers;
        while (xfers - x0 < 5) step();
        s_valid = '0;
        reload  = '0;
        repeat (3) step();
        p0 = pulses;
        pulse_reset();
        repeat (LAT + 6) step();
        check("rst_drop_pulses", 64'(pulses - p0), 64'd0);

        // Random traffic with sporadic enable gaps.
        repeat (400) begin
            for (int i = 0; i < R; i++) begin
                if (!s_valid[i] && $urandom_range(0, 1) == 1) begin
                    s_valid[i] = 1'b1;
                    s_data[i*FS +: FS] = rand_float();
                end
            end
            enable = ($urandom_range(0, 7) != 0);
            step();
        end
        enable = 1'b1;
        s_valid = '0;
        waited = 0;
        while (sb.size() > 0 && waited < 50) begin
            step();
            waited++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
